if_fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage. It drives the IF stage's PC-select and branch-address inputs, the PC-register enable and the IF/ID latch enable/valid. It runs a request/ready handshake with instruction memory and absorbs hazard-unit stalls. It also resolves branch redirects that arrive while a fetch is still outstanding, so a stale instruction never enters ID.

---
 rtl/if_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: drives PC select/enable and the IF/ID latch, runs the imem
// request/ready handshake and resolves branch redirects that land on an outstanding fetch.
module if_fetch_ctrl #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned RESET_HOLD = 2
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_branch_taken,
   input  logic [ADDR_W-1:0] i_branch_address,
   input  logic              i_stall,
   input  logic              i_imem_ready,
   output logic              o_imem_req,
   output logic              o_pc_enable,
   output logic              o_select,
   output logic [ADDR_W-1:0] o_branch_address,
   output logic              o_ifid_enable,
   output logic              o_ifid_valid,
   output logic              o_flush,
   output logic [1:0]        o_state
);

   typedef enum logic [1:0] {
      StBoot     = 2'd0,
      StFetch    = 2'd1,
      StHold     = 2'd2,
      StRedirect = 2'd3
   } state_e;

   localparam logic [3:0] HoldInit = 4'(RESET_HOLD);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] pend_q, pend_d;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= StBoot;
         cnt_q   <= HoldInit;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      pend_d           = pend_q;
      o_imem_req       = 1'b0;
      o_pc_enable      = 1'b0;
      o_select         = 1'b0;
      o_branch_address = pend_q;
      o_ifid_enable    = 1'b0;
      o_ifid_valid     = 1'b0;
      o_flush          = 1'b0;

      unique case (state_q)
         StBoot: begin
            if (cnt_q == 4'd0) begin
               state_d = StFetch;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         StFetch: begin
            o_imem_req = 1'b1;
            if (i_branch_taken && i_imem_ready) begin
               // Redirect on the same edge; the just-returned word is the wrong path.
               o_pc_enable      = 1'b1;
               o_select         = 1'b1;
               o_branch_address = i_branch_address;
               o_flush          = 1'b1;
               o_ifid_enable    = 1'b1;
            end else if (i_branch_taken) begin
               pend_d  = i_branch_address;
               o_flush = 1'b1;
               state_d = StRedirect;
            end else if (i_imem_ready && !i_stall) begin
               o_pc_enable   = 1'b1;
               o_ifid_enable = 1'b1;
               o_ifid_valid  = 1'b1;
            end else if (i_imem_ready) begin
               state_d = StHold;
            end
         end

         StHold: begin
            if (i_branch_taken) begin
               o_pc_enable      = 1'b1;
               o_select         = 1'b1;
               o_branch_address = i_branch_address;
               o_flush          = 1'b1;
               o_ifid_enable    = 1'b1;
               state_d          = StFetch;
            end else if (!i_stall) begin
               state_d = StFetch;
            end
         end

         StRedirect: begin
            o_imem_req = 1'b1;
            if (i_branch_taken) begin
               pend_d  = i_branch_address;
               o_flush = 1'b1;
            end
            if (i_imem_ready) begin
               // Newest target wins, including one arriving on the ready cycle itself.
               o_branch_address = i_branch_taken ? i_branch_address : pend_q;
               o_pc_enable      = 1'b1;
               o_select         = 1'b1;
               o_ifid_enable    = 1'b1;
               state_d          = StFetch;
            end
         end

         default: state_d = StBoot;
      endcase
   end

   assign o_state = state_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: the driver queues hand-computed expected outputs per cycle,
// a monitor pops and compares them mid-cycle.
module tb_if_fetch_ctrl;

   typedef struct packed {
      logic        req;
      logic        pce;
      logic        sel;
      logic [31:0] ba;
      logic        ife;
      logic        ifv;
      logic        flush;
      logic [1:0]  st;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        taken = 1'b0;
   logic [31:0] addr = '0;
   logic        stall = 1'b0;
   logic        ready = 1'b0;
   logic        req, pce, sel, ife, ifv, flush;
   logic [31:0] ba;
   logic [1:0]  st;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   if_fetch_ctrl #(.ADDR_W(32), .RESET_HOLD(2)) dut (
      .i_clock          (clk),
      .i_reset          (rst),
      .i_branch_taken   (taken),
      .i_branch_address (addr),
      .i_stall          (stall),
      .i_imem_ready     (ready),
      .o_imem_req       (req),
      .o_pc_enable      (pce),
      .o_select         (sel),
      .o_branch_address (ba),
      .o_ifid_enable    (ife),
      .o_ifid_valid     (ifv),
      .o_flush          (flush),
      .o_state          (st)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic r, input logic p, input logic s, input logic [31:0] a,
                               input logic e, input logic v, input logic f, input logic [1:0] t);
      exp_t x;
      x.req = r; x.pce = p; x.sel = s; x.ba = a; x.ife = e; x.ifv = v; x.flush = f; x.st = t;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, name, act, want);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; expected values describe that cycle.
   task automatic step(input logic r, input logic tk, input logic [31:0] a, input logic sl,
                       input logic rd, input exp_t e);
      @(posedge clk);
      #1;
      rst = r; taken = tk; addr = a; stall = sl; ready = rd;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("imem_req",  32'(req),   32'(e.req));
         chk("pc_enable", 32'(pce),   32'(e.pce));
         chk("select",    32'(sel),   32'(e.sel));
         chk("branch_address", ba,    e.ba);
         chk("ifid_enable", 32'(ife), 32'(e.ife));
         chk("ifid_valid",  32'(ifv), 32'(e.ifv));
         chk("flush",     32'(flush), 32'(e.flush));
         chk("state",     32'(st),    32'(e.st));
         cyc++;
      end
   end

   initial begin
      //        rst tk addr      sl rd    req pce sel ba        ife ifv fl st
      step(1, 0, 32'h0,   0, 1, mk(0, 0, 0, 32'h0,   0, 0, 0, 0));
      // Boot hold: two decrements then the third edge enters FETCH.
      step(0, 0, 32'h0,   0, 1, mk(0, 0, 0, 32'h0,   0, 0, 0, 0));
      step(0, 0, 32'h0,   0, 1, mk(0, 0, 0, 32'h0,   0, 0, 0, 0));
      step(0, 0, 32'h0,   0, 1, mk(0, 0, 0, 32'h0,   0, 0, 0, 0));
      step(0, 0, 32'h0,   0, 1, mk(1, 1, 0, 32'h0,   1, 1, 0, 1));
      step(0, 0, 32'h0,   0, 1, mk(1, 1, 0, 32'h0,   1, 1, 0, 1));
      // Taken with immediate ready: one bubble.
      step(0, 1, 32'h402, 0, 1, mk(1, 1, 1, 32'h402, 1, 0, 1, 1));
      step(0, 0, 32'h0,   0, 1, mk(1, 1, 0, 32'h0,   1, 1, 0, 1));
      // Taken during outstanding fetch, retargeted, stall ignored in REDIRECT.
      step(0, 1, 32'h500, 0, 0, mk(1, 0, 0, 32'h0,   0, 0, 1, 1));
      step(0, 1, 32'h600, 0, 0, mk(1, 0, 0, 32'h500, 0, 0, 1, 3));
      step(0, 0, 32'h0,   1, 0, mk(1, 0, 0, 32'h600, 0, 0, 0, 3));
      step(0, 0, 32'h0,   0, 1, mk(1, 1, 1, 32'h600, 1, 0, 0, 3));
      step(0, 0, 32'h0,   0, 1, mk(1, 1, 0, 32'h600, 1, 1, 0, 1));
      // Stall four cycles on ready: discard, HOLD with no request, resume.
      step(0, 0, 32'h0,   1, 1, mk(1, 0, 0, 32'h600, 0, 0, 0, 1));
      step(0, 0, 32'h0,   1, 1, mk(0, 0, 0, 32'h600, 0, 0, 0, 2));
      step(0, 0, 32'h0,   1, 1, mk(0, 0, 0, 32'h600, 0, 0, 0, 2));
      step(0, 0, 32'h0,   1, 1, mk(0, 0, 0, 32'h600, 0, 0, 0, 2));
      step(0, 0, 32'h0,   0, 1, mk(0, 0, 0, 32'h600, 0, 0, 0, 2));
      step(0, 0, 32'h0,   0, 1, mk(1, 1, 0, 32'h600, 1, 1, 0, 1));
      // Taken while in HOLD.
      step(0, 0, 32'h0,   1, 1, mk(1, 0, 0, 32'h600, 0, 0, 0, 1));
      step(0, 1, 32'h700, 1, 1, mk(0, 1, 1, 32'h700, 1, 0, 1, 2));
      step(0, 0, 32'h0,   0, 1, mk(1, 1, 0, 32'h600, 1, 1, 0, 1));
      // No ready: request held, nothing enabled.
      step(0, 0, 32'h0,   0, 0, mk(1, 0, 0, 32'h600, 0, 0, 0, 1));
      step(0, 1, 32'h800, 0, 0, mk(1, 0, 0, 32'h600, 0, 0, 1, 1));
      step(0, 0, 32'h0,   0, 0, mk(1, 0, 0, 32'h800, 0, 0, 0, 3));
      // Asynchronous reset mid-cycle in REDIRECT, then BOOT ignores taken/stall.
      step(1, 0, 32'h0,   0, 0, mk(0, 0, 0, 32'h0,   0, 0, 0, 0));
      step(0, 1, 32'h900, 1, 1, mk(0, 0, 0, 32'h0,   0, 0, 0, 0));
      step(0, 1, 32'h900, 1, 1, mk(0, 0, 0, 32'h0,   0, 0, 0, 0));
      step(0, 0, 32'h0,   0, 1, mk(0, 0, 0, 32'h0,   0, 0, 0, 0));
      step(0, 0, 32'h0,   0, 1, mk(1, 1, 0, 32'h0,   1, 1, 0, 1));

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
